// File: rtl/hazard_detect.sv
// hazard_detect: pipeline hazard FSM producing registered stall/flush controls.
// Optional HAZARD_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
`default_nettype none

module hazard_detect #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_valid,
  input  logic       ex_branch_taken,
  input  logic       mem_busy,
  output logic       hazard_stall,
  output logic       hazard_flush,
  output logic       branch_taken,
  output logic [1:0] stall_cause,
  output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES);
  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  state_t     state, state_next, idle_target;
  logic       pend, pend_next;
  logic [3:0] fcnt, fcnt_next;
  logic [7:0] mcnt, mcnt_next;
  logic       load_use, br, timeout_set;
  logic       stall_d, flush_d;
  logic [1:0] cause_d;

  assign load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((id_rs1_used & (id_rs1 == ex_rd)) |
                     (id_rs2_used & (id_rs2 == ex_rd)));
  assign br = ex_branch_valid & ex_branch_taken;

  always_comb begin
    idle_target = IDLE;
    if (br)            idle_target = FLUSH;
    else if (mem_busy) idle_target = MEM_WAIT;
    else if (load_use) idle_target = LOAD_STALL;
  end

  always_comb begin
    state_next = state;
    pend_next  = pend;
    fcnt_next  = fcnt;
    mcnt_next  = mcnt;
    case (state)
      IDLE: state_next = idle_target;
      LOAD_STALL: begin
        state_next = idle_target;
        if (br) pend_next = 1'b1;
      end
      MEM_WAIT: begin
        if (mcnt != TIMEOUT_VAL) mcnt_next = mcnt + 8'd1;
        if (mem_busy) begin
          if (br) pend_next = 1'b1;
        end else begin
          // A branch arriving on the release cycle is treated as pending too
          state_next = (pend | br) ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        if (br)                fcnt_next = FLUSH_LOAD;
        else if (fcnt <= 4'd1) state_next = IDLE;
        else                   fcnt_next = fcnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
    if (state_next == FLUSH && state != FLUSH) begin
      fcnt_next = FLUSH_LOAD;
      pend_next = 1'b0;
    end
    if (state_next == MEM_WAIT && state != MEM_WAIT) mcnt_next = 8'd0;
  end

  assign timeout_set = (state == MEM_WAIT) && (mcnt_next == TIMEOUT_VAL);

  // Outputs are decoded from the next state so they register with the state
  always_comb begin
    stall_d = 1'b0;
    flush_d = 1'b0;
    cause_d = 2'd0;
    case (state_next)
      LOAD_STALL: begin stall_d = 1'b1; cause_d = 2'd1; end
      MEM_WAIT:   begin stall_d = 1'b1; cause_d = 2'd2; end
      FLUSH:      begin flush_d = 1'b1; cause_d = 2'd3; end
      default:    cause_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= 1'b0;
      fcnt  <= 4'd0;
      mcnt  <= 8'd0;
    end else begin
      state <= state_next;
      pend  <= pend_next;
      fcnt  <= fcnt_next;
      mcnt  <= mcnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hazard_stall <= 1'b0;
      hazard_flush <= 1'b0;
      branch_taken <= 1'b0;
      stall_cause  <= 2'd0;
      mem_timeout  <= 1'b0;
    end else begin
      hazard_stall <= stall_d;
      hazard_flush <= flush_d;
      branch_taken <= flush_d;
      stall_cause  <= cause_d;
      if (timeout_set) mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic flush_entry;
  assign flush_entry = (state_next == FLUSH) && (state != FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (hazard_stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (flush_entry && flush_cnt != 32'hFFFF_FFFF)  flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_detect.sv
// tb_hazard_detect: directed scoreboard bench for hazard_detect (FLUSH_CYCLES=2, MEM_TIMEOUT=3).
`default_nettype none

module tb_hazard_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_valid, ex_mem_read;
  logic       ex_branch_valid, ex_branch_taken, mem_busy;
  logic       hazard_stall, hazard_flush, branch_taken, mem_timeout;
  logic [1:0] stall_cause;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic  tm_exp = 1'b0;
  logic [5:0] exp_q[$];
  string      nm_q[$];

  always #5 clk = ~clk;

  hazard_detect #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_valid(ex_branch_valid), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy),
    .hazard_stall(hazard_stall), .hazard_flush(hazard_flush),
    .branch_taken(branch_taken), .stall_cause(stall_cause),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic clear_inputs();
    rst = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    ex_branch_valid = 1'b0; ex_branch_taken = 1'b0;
    mem_busy = 1'b0;
  endtask

  // Queue the outputs expected after the coming edge, then advance one cycle
  task automatic cyc(input string nm, input logic s, input logic f,
                     input logic b, input logic [1:0] c);
    exp_q.push_back({s, f, b, c, tm_exp});
    nm_q.push_back(nm);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic load(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = rd;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
  endtask

  task automatic branch();
    ex_branch_valid = 1'b1; ex_branch_taken = 1'b1;
  endtask

  // Monitor: compares every registered output set against the scoreboard
  initial begin
    logic [5:0] act, expv;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        nm   = nm_q.pop_front();
        act  = {hazard_stall, hazard_flush, branch_taken, stall_cause, mem_timeout};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL %s: got stall/flush/taken/cause/tmo=%b required %b", nm, act, expv);
        end
        checks++;
        if (hazard_stall === 1'b1 && hazard_flush === 1'b1) begin
          errors++;
          $display("FAIL %s_excl: stall and flush both 1, required not both", nm);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b1; cyc("reset0", 0, 0, 0, 2'd0);
    rst = 1'b1; cyc("reset1", 0, 0, 0, 2'd0);
    cyc("idle", 0, 0, 0, 2'd0);

    load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); cyc("lu_rs1", 1, 0, 0, 2'd1);
    cyc("lu_rs1_end", 0, 0, 0, 2'd0);
    load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); cyc("lu_rd0", 0, 0, 0, 2'd0);
    load(5'd7, 5'd1, 1'b1, 5'd7, 1'b1); cyc("lu_rs2", 1, 0, 0, 2'd1);
    load(5'd7, 5'd1, 1'b1, 5'd7, 1'b0); cyc("lu_rs2_unused", 0, 0, 0, 2'd0);
    load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); ex_valid = 1'b0; cyc("lu_invalid", 0, 0, 0, 2'd0);

    mem_busy = 1'b1; cyc("mem2_a", 1, 0, 0, 2'd2);
    mem_busy = 1'b1; cyc("mem2_b", 1, 0, 0, 2'd2);
    cyc("mem2_end", 0, 0, 0, 2'd0);

    mem_busy = 1'b1; cyc("mem4_1", 1, 0, 0, 2'd2);
    mem_busy = 1'b1; cyc("mem4_2", 1, 0, 0, 2'd2);
    mem_busy = 1'b1; cyc("mem4_3", 1, 0, 0, 2'd2);
    tm_exp = 1'b1;
    mem_busy = 1'b1; cyc("mem4_4_tmo", 1, 0, 0, 2'd2);
    cyc("mem4_end", 0, 0, 0, 2'd0);
    cyc("tmo_sticky", 0, 0, 0, 2'd0);

    branch(); cyc("br1_f1", 0, 1, 1, 2'd3);
    cyc("br1_f2", 0, 1, 1, 2'd3);
    cyc("br1_end", 0, 0, 0, 2'd0);

    branch(); cyc("br2_f1", 0, 1, 1, 2'd3);
    branch(); cyc("br2_f2", 0, 1, 1, 2'd3);
    cyc("br2_f3", 0, 1, 1, 2'd3);
    cyc("br2_end", 0, 0, 0, 2'd0);

    branch(); mem_busy = 1'b1; cyc("sim_f1", 0, 1, 1, 2'd3);
    mem_busy = 1'b1; load(5'd3, 5'd3, 1'b1, 5'd0, 1'b0); cyc("sim_f2", 0, 1, 1, 2'd3);
    cyc("sim_end", 0, 0, 0, 2'd0);

    mem_busy = 1'b1; cyc("mwbr_s1", 1, 0, 0, 2'd2);
    mem_busy = 1'b1; branch(); cyc("mwbr_s2", 1, 0, 0, 2'd2);
    mem_busy = 1'b1; cyc("mwbr_s3", 1, 0, 0, 2'd2);
    cyc("mwbr_f1", 0, 1, 1, 2'd3);
    cyc("mwbr_f2", 0, 1, 1, 2'd3);
    cyc("mwbr_end", 0, 0, 0, 2'd0);

    branch(); cyc("rst_f1", 0, 1, 1, 2'd3);
    cyc("rst_f2", 0, 1, 1, 2'd3);
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 32'd11 || flush_cnt !== 32'd5) begin
      errors++;
      $display("FAIL perf_counts: got stall_cnt=%0d flush_cnt=%0d required 11 and 5", stall_cnt, flush_cnt);
    end
`endif
    tm_exp = 1'b0;
    rst = 1'b1; cyc("rst_abort", 0, 0, 0, 2'd0);
    cyc("post_rst", 0, 0, 0, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: got stall_cnt=%0d flush_cnt=%0d required 0 and 0", stall_cnt, flush_cnt);
    end
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_detect.md
HAZARD_DETECT -- requirements
Module: hazard_detect

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2 (range 1..15), giving cycles hazard_flush is held per taken branch.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255 (range 1..255), giving the maximum MEM_WAIT cycles before mem_timeout sets.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports id_rs1 and id_rs2, input, 5 each, ID-stage source register numbers.
REQ-006 SHALL have ports id_rs1_used and id_rs2_used, input, 1 each, marking that the source is actually read.
REQ-007 SHALL have ports ex_valid, ex_mem_read (1 each) and ex_rd (5), input, describing the EX-stage instruction.
REQ-008 SHALL have ports ex_branch_valid and ex_branch_taken, input, 1 each, giving the branch/jump resolution in EX.
REQ-009 SHALL have port mem_busy, input, 1, data memory not ready.
REQ-010 SHALL have ports hazard_stall, hazard_flush and branch_taken, output, 1 each, registered, driving the pipeline controller.
REQ-011 SHALL have port stall_cause, output, 2, registered: 0 none, 1 load-use, 2 memory, 3 flush.
REQ-012 SHALL have port mem_timeout, output, 1, registered and sticky.

Function
REQ-013 SHALL define load_use = ex_valid & ex_mem_read & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)).
REQ-014 SHALL define br = ex_branch_valid & ex_branch_taken.
REQ-015 SHALL implement FSM states IDLE, LOAD_STALL, MEM_WAIT and FLUSH; outputs derive from the registered state only (1-cycle latency from the input condition).
REQ-016 IDLE SHALL transition in priority order: br -> FLUSH; mem_busy -> MEM_WAIT; load_use -> LOAD_STALL; otherwise remain.
REQ-017 LOAD_STALL SHALL last exactly 1 cycle with hazard_stall=1 and stall_cause=1, then re-evaluate using the IDLE rules.
REQ-018 MEM_WAIT SHALL hold hazard_stall=1 and stall_cause=2 while mem_busy=1; on mem_busy=0 it goes to FLUSH if a branch is pending, else to IDLE.
REQ-019 br seen in MEM_WAIT or LOAD_STALL SHALL set a pending-branch flag, which clears on entry to FLUSH.
REQ-020 FLUSH SHALL hold hazard_flush=1, branch_taken=1 and stall_cause=3 for FLUSH_CYCLES cycles via a down-counter, then go to IDLE.
REQ-021 br during FLUSH SHALL reload the counter to FLUSH_CYCLES.
REQ-022 load_use and mem_busy SHALL be ignored during FLUSH, since the flushed instructions are squashed.
REQ-023 hazard_stall and hazard_flush SHALL never both be 1.
REQ-024 MEM_WAIT SHALL count cycles in an 8-bit counter; when the count reaches MEM_TIMEOUT, mem_timeout sets and the count saturates, but the FSM keeps waiting.
REQ-025 The MEM_WAIT counter SHALL clear on every entry to MEM_WAIT.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set state=IDLE and clear the pending-branch flag and both counters.
REQ-027 When rst=1 at a clock edge, the block SHALL drive hazard_stall, hazard_flush, branch_taken, stall_cause and mem_timeout to 0.
REQ-028 Reset mid-stall or mid-flush SHALL abort it with no residual output on the following cycle.
REQ-029 mem_timeout SHALL clear only on rst.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN, when defined, SHALL add outputs stall_cnt[31:0] (cycles with hazard_stall=1) and flush_cnt[31:0] (FLUSH entries, not reloads).
REQ-031 stall_cnt and flush_cnt SHALL saturate at 0xFFFFFFFF and reset to 0.
REQ-032 Without HAZARD_PERF_CNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 at cycle N -> hazard_stall=1 and stall_cause=1 in cycle N+1 only; ex_rd=0 -> no stall.
REQ-034 Memory wait: mem_busy=1 for 4 cycles -> hazard_stall=1 for 4 consecutive cycles starting 1 cycle later; MEM_TIMEOUT=3 -> mem_timeout=1 and stays 1.
REQ-035 Branch: single br pulse with FLUSH_CYCLES=2 -> hazard_flush=branch_taken=1 for exactly 2 cycles; a second br in the first flush cycle -> 3 cycles in total.
REQ-036 Simultaneous: br with mem_busy=1 in IDLE -> FLUSH, with no stall.
REQ-037 br during MEM_WAIT -> flush of 2 cycles immediately after the stall ends, with no gap cycle.
REQ-038 Reset: rst=1 during the FLUSH second cycle -> all outputs 0 the next cycle; with HAZARD_PERF_CNT_EN, the counters read 0.
